// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared definitions for the register bank.
//   - clr_state_e : clear-sequencer state encoding (IDLE, CLEAR, DONE)
//   - XLEN_DEF / NREGS_DEF : default word width and register count
//   - merge_byte  : selects the new or old byte of a word under a strobe;
//                   used by both the array write path and the read bypass
package reg_bank_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       strb);
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/reg_bank_clr_fsm.sv
// reg_bank_clr_fsm: clear sequencer for the register bank.
// Sweeps the array one word per cycle after a clr_req in IDLE, then emits a
// one-cycle done pulse and returns to IDLE.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clr_req_i      : start request, sampled only in IDLE
//   clr_en_o       : array word at clr_addr_o is zeroed at this edge
//   clr_addr_o     : current sweep address (counter)
//   idle_o         : sequencer is in IDLE (writes may be accepted)
//   clr_busy_o     : registered, high in CLEAR and DONE
//   clr_done_o     : registered, high for the single DONE cycle
module reg_bank_clr_fsm
  import reg_bank_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_req_i,
  output logic          clr_en_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          idle_o,
  output logic          clr_busy_o,
  output logic          clr_done_o
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  clr_state_e    state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;

  // Terminal compare at NREGS-1 means the counter never wraps into a
  // second pass; clr_req outside IDLE is simply not looked at.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (clr_req_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = cnt_q;
  assign idle_o     = (state_q == ST_IDLE);
  assign clr_busy_o = busy_q;
  assign clr_done_o = done_q;

endmodule

// File: rtl/reg_bank.sv
// reg_bank: NREGS x XLEN architectural register file.
// One byte-strobed synchronous write port, two combinational read ports with
// optional same-cycle write-through, optional hard-wired zero register, and a
// word-per-cycle clear sweep.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (zeroes array)
//   we, waddr, wdata  : write enable, address, data
//   wstrb             : byte strobes, bit i covers wdata[8i+7:8i]
//   ra1, ra2          : read addresses
//   rd1, rd2          : combinational read data
//   clr_req           : start clear sweep (level, sampled on clk in IDLE)
//   clr_busy          : sweep in progress (CLEAR or DONE)
//   clr_done          : one-cycle pulse after the last word is cleared
//   wr_drop           : a strobed write was rejected this cycle (sweep active)
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS),
  localparam int NB      = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [NB-1:0]   wstrb,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done,
  output logic            wr_drop
);

  function automatic logic [XLEN-1:0] merge_word(input logic [XLEN-1:0] old_w,
                                                 input logic [XLEN-1:0] new_w,
                                                 input logic [NB-1:0]   strb);
    logic [XLEN-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      res[8*b +: 8] = merge_byte(old_w[8*b +: 8], new_w[8*b +: 8], strb[b]);
    end
    return res;
  endfunction

  logic            clr_en;
  logic [AW-1:0]   clr_addr;
  logic            fsm_idle;
  logic            wr_x0;
  logic            wr_acc;
  logic [XLEN-1:0] wr_word_d;
  logic [XLEN-1:0] mem_q [NREGS];

  reg_bank_clr_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr_fsm (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_req_i  (clr_req),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr),
    .idle_o     (fsm_idle),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done)
  );

  // Write qualification: x0 writes vanish silently, while any strobed write
  // arriving during a sweep is rejected and flagged.
  assign wr_x0     = (ZERO_REG != 0) && (waddr == '0);
  assign wr_acc    = we && (wstrb != '0) && fsm_idle && !wr_x0;
  assign wr_drop   = we && (wstrb != '0) && !fsm_idle;
  assign wr_word_d = merge_word(mem_q[waddr], wdata, wstrb);

  // Array update edge: sweep and writes are mutually exclusive since writes
  // are accepted only in IDLE; the sweep is given priority regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem_q[waddr] <= wr_word_d;
    end
  end

  // Read ports: forward the merged word when the same address is being
  // written this cycle, so the reader sees the post-edge value early.
  always_comb begin
    rd1 = mem_q[ra1];
    if ((BYPASS != 0) && wr_acc && (waddr == ra1)) begin
      rd1 = merge_word(mem_q[ra1], wdata, wstrb);
    end
    if ((ZERO_REG != 0) && (ra1 == '0)) begin
      rd1 = '0;
    end
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if ((BYPASS != 0) && wr_acc && (waddr == ra2)) begin
      rd2 = merge_word(mem_q[ra2], wdata, wstrb);
    end
    if ((ZERO_REG != 0) && (ra2 == '0)) begin
      rd2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed self-checking bench for reg_bank (default parameters:
// XLEN=32, NREGS=32, ZERO_REG=1, BYPASS=1).
module tb_reg_bank;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;
  logic        wr_drop;

  int tests;
  int fails;

  reg_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    ra1 = 5'd5; ra2 = 5'd31; clr_req = 1'b0;
    #1;
    step(); step();
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL reset_rd1: got %h expected %h", rd1, 32'h0); end
    tests++; if (rd2 !== 32'h0) begin fails++; $display("FAIL reset_rd2: got %h expected %h", rd2, 32'h0); end
    tests++; if (clr_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", clr_busy); end
    tests++; if (clr_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", clr_done); end
    tests++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL reset_drop: got %b expected 0", wr_drop); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wstrb = 4'hF; ra2 = 5'd5; ra1 = 5'd6;
    #1;
    tests++; if (rd2 !== 32'hDEADBEEF) begin fails++; $display("FAIL full_bypass: got %h expected %h", rd2, 32'hDEADBEEF); end
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL other_reg: got %h expected %h", rd1, 32'h0); end
    step();
    we = 1'b0; ra1 = 5'd5;
    #1;
    tests++; if (rd1 !== 32'hDEADBEEF) begin fails++; $display("FAIL full_write: got %h expected %h", rd1, 32'hDEADBEEF); end
  endtask

  task automatic test_partial_bypass();
    we = 1'b1; waddr = 5'd5; wdata = 32'h11223344; wstrb = 4'b0101; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    tests++; if (rd2 !== 32'hDE22BE44) begin fails++; $display("FAIL strb_bypass: got %h expected %h", rd2, 32'hDE22BE44); end
    step();
    we = 1'b0;
    #1;
    tests++; if (rd1 !== 32'hDE22BE44) begin fails++; $display("FAIL strb_write: got %h expected %h", rd1, 32'hDE22BE44); end
  endtask

  task automatic test_no_strobe();
    we = 1'b1; waddr = 5'd5; wdata = 32'h00000000; wstrb = 4'h0; ra2 = 5'd5;
    #1;
    tests++; if (rd2 !== 32'hDE22BE44) begin fails++; $display("FAIL nostrb_bypass: got %h expected %h", rd2, 32'hDE22BE44); end
    tests++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL nostrb_drop: got %b expected 0", wr_drop); end
    step();
    we = 1'b0;
    #1;
    tests++; if (rd2 !== 32'hDE22BE44) begin fails++; $display("FAIL nostrb_hold: got %h expected %h", rd2, 32'hDE22BE44); end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; ra1 = 5'd0;
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL x0_bypass: got %h expected %h", rd1, 32'h0); end
    tests++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL x0_drop: got %b expected 0", wr_drop); end
    step();
    we = 1'b0;
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL x0_read: got %h expected %h", rd1, 32'h0); end
  endtask

  task automatic test_back_to_back();
    we = 1'b1; waddr = 5'd8; wdata = 32'h08080808; wstrb = 4'hF;
    step();
    waddr = 5'd9; wdata = 32'h09090909; ra1 = 5'd8; ra2 = 5'd9;
    #1;
    tests++; if (rd1 !== 32'h08080808) begin fails++; $display("FAIL b2b_first: got %h expected %h", rd1, 32'h08080808); end
    tests++; if (rd2 !== 32'h09090909) begin fails++; $display("FAIL b2b_second_byp: got %h expected %h", rd2, 32'h09090909); end
    step();
    we = 1'b0;
    #1;
    tests++; if (rd2 !== 32'h09090909) begin fails++; $display("FAIL b2b_second: got %h expected %h", rd2, 32'h09090909); end
  endtask

  task automatic test_clear();
    int n_clear;
    int n_done;
    bit ended;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i); wstrb = 4'hF;
      step();
    end
    we = 1'b0; ra1 = 5'd1; ra2 = 5'd31;
    #1;
    tests++; if (rd1 !== 32'd1) begin fails++; $display("FAIL fill_x1: got %h expected %h", rd1, 32'd1); end
    tests++; if (rd2 !== 32'd31) begin fails++; $display("FAIL fill_x31: got %h expected %h", rd2, 32'd31); end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    n_clear = 0; n_done = 0; ended = 1'b0;
    // j counts edges after the sampling edge N; sample point is edge N+j.
    for (int j = 0; j < 40 && !ended; j++) begin
      we = 1'b0;
      if (j == 5) clr_req = 1'b1;
      if (j == 6) clr_req = 1'b0;
      if (j == 10) begin
        ra1 = 5'd9; ra2 = 5'd10;
        #1;
        tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL sweep_x9_cleared: got %h expected %h", rd1, 32'h0); end
        tests++; if (rd2 !== 32'd10) begin fails++; $display("FAIL sweep_x10_old: got %h expected %h", rd2, 32'd10); end
      end
      if (j == 12) begin
        we = 1'b1; waddr = 5'd2; wdata = 32'hAAAAAAAA; wstrb = 4'hF; ra1 = 5'd2;
        #1;
        tests++; if (wr_drop !== 1'b1) begin fails++; $display("FAIL sweep_wr_drop: got %b expected 1", wr_drop); end
        tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL sweep_no_bypass: got %h expected %h", rd1, 32'h0); end
      end
      if (clr_busy === 1'b1 && clr_done !== 1'b1) n_clear++;
      if (clr_done === 1'b1) begin
        n_done++;
        tests++; if (clr_busy !== 1'b1) begin fails++; $display("FAIL done_busy: got %b expected 1", clr_busy); end
      end
      if (clr_busy !== 1'b1) ended = 1'b1;
      else step();
    end
    we = 1'b0;
    tests++; if (!ended) begin fails++; $display("FAIL sweep_timeout: got busy %b expected 0 within 40 cycles", clr_busy); end
    tests++; if (n_clear !== 32) begin fails++; $display("FAIL sweep_len: got %0d expected %0d", n_clear, 32); end
    tests++; if (n_done !== 1) begin fails++; $display("FAIL done_pulses: got %0d expected %0d", n_done, 1); end
    for (int i = 0; i < 32; i += 2) begin
      ra1 = 5'(i); ra2 = 5'(i + 1);
      #1;
      tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL post_clear_x%0d: got %h expected %h", i, rd1, 32'h0); end
      tests++; if (rd2 !== 32'h0) begin fails++; $display("FAIL post_clear_x%0d: got %h expected %h", i + 1, rd2, 32'h0); end
    end
    step();
    tests++; if (clr_busy !== 1'b0) begin fails++; $display("FAIL no_restart: got busy %b expected 0", clr_busy); end
  endtask

  task automatic test_reset_mid_sweep();
    int n_done;
    we = 1'b1; waddr = 5'd20; wdata = 32'h20202020; wstrb = 4'hF;
    step();
    we = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int j = 0; j < 10; j++) step();
    rst_n = 1'b0; ra1 = 5'd20;
    #1;
    tests++; if (rd1 !== 32'h0) begin fails++; $display("FAIL rst_mid_x20: got %h expected %h", rd1, 32'h0); end
    tests++; if (clr_busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", clr_busy); end
    tests++; if (clr_done !== 1'b0) begin fails++; $display("FAIL rst_mid_done: got %b expected 0", clr_done); end
    tests++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL rst_mid_drop: got %b expected 0", wr_drop); end
    step();
    rst_n = 1'b1;
    we = 1'b1; waddr = 5'd7; wdata = 32'h77777777; wstrb = 4'hF; ra2 = 5'd7;
    #1;
    tests++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL rst_wr_drop: got %b expected 0", wr_drop); end
    tests++; if (rd2 !== 32'h77777777) begin fails++; $display("FAIL rst_wr_bypass: got %h expected %h", rd2, 32'h77777777); end
    step();
    we = 1'b0; ra1 = 5'd7;
    #1;
    tests++; if (rd1 !== 32'h77777777) begin fails++; $display("FAIL rst_wr_accept: got %h expected %h", rd1, 32'h77777777); end
    n_done = 0;
    for (int j = 0; j < 40; j++) begin
      if (clr_done === 1'b1 || clr_busy === 1'b1) n_done++;
      step();
    end
    tests++; if (n_done !== 0) begin fails++; $display("FAIL rst_no_done: got %0d active cycles expected 0", n_done); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write_read();
    test_partial_bypass();
    test_no_strobe();
    test_zero_reg();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
